// File: rtl/ram_bancos_pkg.sv
// Shared types and size helpers for the banked RAM with clear sequencer.
package ram_bancos_pkg;

  typedef enum logic {
    PRONTO   = 1'b0,
    LIMPANDO = 1'b1
  } estado_t;

  function automatic int num_bancos(input int bits_banco);
    return 1 << bits_banco;
  endfunction

  function automatic int prof_banco(input int bits_end, input int bits_banco);
    return 1 << (bits_end - bits_banco);
  endfunction

endpackage

// File: rtl/ram_bancos_param_banco.sv
// One RAM bank: synchronous write, combinational read at the same address.
module banco_ram #(
  parameter int LARGURA    = 16,
  parameter int BITS_LOCAL = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BITS_LOCAL-1:0] addr,
  input  logic [LARGURA-1:0]    din,
  output logic [LARGURA-1:0]    dout
);

  logic [LARGURA-1:0] mem_q [2**BITS_LOCAL];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= din;
  end

  assign dout = mem_q[addr];

endmodule

// File: rtl/ram_bancos_param.sv
// Banked single-port RAM: registered read with valid strobe, write-first
// forwarding, and a sequencer that zeroes all banks after reset or on request.
module ram_bancos_param
  import ram_bancos_pkg::*;
#(
  parameter int                 LARGURA     = 16,
  parameter int                 BITS_END    = 14,
  parameter int                 BITS_BANCO  = 2,
  parameter logic [LARGURA-1:0] VALOR_LIMPO = '0
) (
  input  logic                clock_sistema,
  input  logic                reset_sistema,
  input  logic [LARGURA-1:0]  entrada_dados,
  input  logic [BITS_END-1:0] endereco_mem,
  input  logic                controle_escrita,
  input  logic                habilita_leitura,
  input  logic                limpar,
  output logic [LARGURA-1:0]  saida_dados,
  output logic                saida_valida,
  output logic                ocupado
);

  localparam int NUM_BANCOS = num_bancos(BITS_BANCO);
  localparam int BITS_LOCAL = BITS_END - BITS_BANCO;
  localparam int PROF_BANCO = prof_banco(BITS_END, BITS_BANCO);
  localparam logic [BITS_LOCAL-1:0] ULTIMO = BITS_LOCAL'(PROF_BANCO - 1);

  estado_t                   estado_q, estado_d;
  logic [BITS_LOCAL-1:0]     contador_q, contador_d;
  logic [LARGURA-1:0]        saida_dados_q, saida_dados_d;
  logic                      saida_valida_q, saida_valida_d;

  logic [BITS_BANCO-1:0]     banco_sel;
  logic [BITS_LOCAL-1:0]     offset;
  logic [NUM_BANCOS-1:0]     sel_oh;
  logic [NUM_BANCOS-1:0]     we_banco;
  logic [BITS_LOCAL-1:0]     addr_banco;
  logic [LARGURA-1:0]        din_banco;
  logic [NUM_BANCOS-1:0][LARGURA-1:0] rd_banco;
  logic                      limpando;

  assign banco_sel = endereco_mem[BITS_END-1 -: BITS_BANCO];
  assign offset    = endereco_mem[BITS_LOCAL-1:0];
  assign limpando  = (estado_q == LIMPANDO);

  always_comb begin
    sel_oh            = '0;
    sel_oh[banco_sel] = 1'b1;
  end

  // While clearing, every bank is written at the sequencer address in parallel.
  always_comb begin
    we_banco   = '0;
    addr_banco = offset;
    din_banco  = entrada_dados;
    if (limpando) begin
      we_banco   = '1;
      addr_banco = contador_q;
      din_banco  = VALOR_LIMPO;
    end else if (controle_escrita) begin
      we_banco   = sel_oh;
    end
  end

  for (genvar g = 0; g < NUM_BANCOS; g++) begin : g_banco
    banco_ram #(
      .LARGURA    (LARGURA),
      .BITS_LOCAL (BITS_LOCAL)
    ) u_banco (
      .clk  (clock_sistema),
      .we   (we_banco[g]),
      .addr (addr_banco),
      .din  (din_banco),
      .dout (rd_banco[g])
    );
  end

  always_comb begin
    estado_d       = estado_q;
    contador_d     = contador_q;
    saida_dados_d  = saida_dados_q;
    saida_valida_d = 1'b0;
    case (estado_q)
      LIMPANDO: begin
        contador_d = contador_q + 1'b1;
        if (contador_q == ULTIMO) begin
          estado_d   = PRONTO;
          contador_d = '0;
        end
      end
      default: begin
        if (habilita_leitura) begin
          saida_valida_d = 1'b1;
          // Single address port: a concurrent write always hits the read word.
          saida_dados_d  = controle_escrita ? entrada_dados : rd_banco[banco_sel];
        end
        if (limpar) begin
          estado_d   = LIMPANDO;
          contador_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock_sistema or posedge reset_sistema) begin
    if (reset_sistema) begin
      estado_q       <= LIMPANDO;
      contador_q     <= '0;
      saida_dados_q  <= '0;
      saida_valida_q <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      contador_q     <= contador_d;
      saida_dados_q  <= saida_dados_d;
      saida_valida_q <= saida_valida_d;
    end
  end

  assign saida_dados  = saida_dados_q;
  assign saida_valida = saida_valida_q;
  assign ocupado      = limpando;

endmodule
